// File: rtl/scalar_decode_stream.sv
// Streams N coefficients in, decodes each to bit = (|coef - t| < t_half),
// packs the bits into OUT_W-bit words and emits them through a 2-entry FIFO.
module scalar_decode_stream #(
    parameter int COEF_W = 30,
    parameter int N      = 1024,
    parameter int OUT_W  = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [COEF_W-1:0] i_t,
    input  logic [COEF_W-2:0] i_t_half,
    output logic              o_busy,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [COEF_W-1:0] i_in_coef,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [OUT_W-1:0]  o_out_word,
    output logic              o_out_last,
    output logic              o_done
);

    localparam int CNT_W = $clog2(N);
    localparam int BIT_W = $clog2(OUT_W);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

    state_t              r_state;
    logic [COEF_W-1:0]   r_tQ;
    logic [COEF_W-2:0]   r_tHalfQ;
    logic [OUT_W-2:0]    r_pack;
    logic [BIT_W-1:0]    r_bitCnt;
    logic [CNT_W-1:0]    r_coefCnt;
    logic [OUT_W-1:0]    r_fifoWord [2];
    logic                r_fifoLast [2];
    logic                r_wrPtr;
    logic                r_rdPtr;
    logic [1:0]          r_count;
    logic                r_done;

    logic                w_accept;
    logic                w_pop;
    logic                w_push;
    logic                w_lastCoef;
    logic [COEF_W-1:0]   w_dist;
    logic                w_bit;

    // in_ready depends only on registered state, never on i_out_ready.
    assign o_in_ready  = (r_state == LOAD) && (r_count != 2'd2);
    assign w_accept    = o_in_ready && i_in_valid;
    assign w_pop       = (r_count != 2'd0) && i_out_ready;
    assign w_push      = w_accept && (r_bitCnt == BIT_W'(OUT_W - 1));
    assign w_lastCoef  = (r_coefCnt == CNT_W'(N - 1));
    assign w_dist      = (i_in_coef >= r_tQ) ? (i_in_coef - r_tQ) : (r_tQ - i_in_coef);
    assign w_bit       = (w_dist < {1'b0, r_tHalfQ});

    assign o_busy      = (r_state != IDLE);
    assign o_out_valid = (r_count != 2'd0);
    assign o_out_word  = r_fifoWord[r_rdPtr];
    assign o_out_last  = o_out_valid && r_fifoLast[r_rdPtr];
    assign o_done      = r_done;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state       <= IDLE;
            r_tQ          <= '0;
            r_tHalfQ      <= '0;
            r_pack        <= '0;
            r_bitCnt      <= '0;
            r_coefCnt     <= '0;
            r_fifoWord[0] <= '0;
            r_fifoWord[1] <= '0;
            r_fifoLast[0] <= 1'b0;
            r_fifoLast[1] <= 1'b0;
            r_wrPtr       <= 1'b0;
            r_rdPtr       <= 1'b0;
            r_count       <= '0;
            r_done        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_state   <= LOAD;
                        r_tQ      <= i_t;
                        r_tHalfQ  <= i_t_half;
                        r_pack    <= '0;
                        r_bitCnt  <= '0;
                        r_coefCnt <= '0;
                    end
                end
                LOAD: begin
                    if (w_accept) begin
                        // The final bit of a word goes straight into the FIFO entry.
                        if (!w_push) begin
                            r_pack[r_bitCnt] <= w_bit;
                        end
                        r_bitCnt  <= w_push ? '0 : r_bitCnt + 1'b1;
                        r_coefCnt <= r_coefCnt + 1'b1;
                        if (w_lastCoef) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (w_pop && r_fifoLast[r_rdPtr]) begin
                        r_state <= IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase

            if (w_push) begin
                r_fifoWord[r_wrPtr] <= {w_bit, r_pack};
                r_fifoLast[r_wrPtr] <= w_lastCoef;
                r_wrPtr             <= ~r_wrPtr;
            end
            if (w_pop) begin
                r_rdPtr <= ~r_rdPtr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

endmodule

// File: tb/tb_scalar_decode_stream.sv
// Directed bench for scalar_decode_stream: default instance plus a small
// COEF_W=16 / N=64 / OUT_W=8 instance, checked against a reference decode model.
module tb_scalar_decode_stream;

    localparam int N     = 1024;
    localparam int OUT_W = 32;
    localparam int WORDS = N / OUT_W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetN, start, inValid, outReady;
    logic [29:0] t, inCoef;
    logic [28:0] tHalf;
    logic        busy, inReady, outValid, outLast, done;
    logic [31:0] outWord;

    logic        sResetN, sStart, sInValid, sOutReady;
    logic [15:0] sT, sInCoef;
    logic [14:0] sTHalf;
    logic        sBusy, sInReady, sOutValid, sOutLast, sDone;
    logic [7:0]  sOutWord;

    int          compared = 0;
    int          mismatched = 0;
    int          cycleCnt = 0;
    int          startCycle = 0;
    int          doneCycleSeen = 0;
    int          popCnt = 0;
    int          doneCnt = 0;
    int          readyMode = 0;
    bit          aborted = 1'b0;
    logic [32:0] expQ [$];
    logic [31:0] capQ [$];
    bit          capLastQ [$];
    logic [7:0]  sCapQ [$];
    bit          sLastQ [$];
    logic [7:0]  sExp [8];
    logic [29:0] modT;
    logic [28:0] modTHalf;
    logic [31:0] modWord = '0;
    int          modBit = 0;
    int          modIdx = 0;
    logic        prevStall = 1'b0;
    logic [31:0] prevWord;
    logic        prevLast;

    scalar_decode_stream #(.COEF_W(30), .N(N), .OUT_W(OUT_W)) dut (
        .i_clk(clk), .i_reset(resetN), .i_start(start), .i_t(t), .i_t_half(tHalf),
        .o_busy(busy), .i_in_valid(inValid), .o_in_ready(inReady), .i_in_coef(inCoef),
        .o_out_valid(outValid), .i_out_ready(outReady), .o_out_word(outWord),
        .o_out_last(outLast), .o_done(done)
    );

    scalar_decode_stream #(.COEF_W(16), .N(64), .OUT_W(8)) dutSmall (
        .i_clk(clk), .i_reset(sResetN), .i_start(sStart), .i_t(sT), .i_t_half(sTHalf),
        .o_busy(sBusy), .i_in_valid(sInValid), .o_in_ready(sInReady), .i_in_coef(sInCoef),
        .o_out_valid(sOutValid), .i_out_ready(sOutReady), .o_out_word(sOutWord),
        .o_out_last(sOutLast), .o_done(sDone)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic bit refBit(input longint c, input longint tc, input longint th);
        longint d = c - tc;
        if (d < 0) d = -d;
        return d < th;
    endfunction

    always @(posedge clk) cycleCnt++;

    initial begin
        outReady = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                0:       outReady = 1'b1;
                1:       outReady = 1'($urandom_range(0, 1));
                default: outReady = 1'b0;
            endcase
        end
    end

    // Reference model and output scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        if (!resetN) begin
            expQ.delete();
            modWord   = '0;
            modBit    = 0;
            modIdx    = 0;
            prevStall = 1'b0;
        end else begin
            if (prevStall) begin
                checkOutput("stallWord", outWord, prevWord);
                checkOutput("stallLast", outLast, prevLast);
            end
            if (start && !busy) begin
                modT     = t;
                modTHalf = tHalf;
                modWord  = '0;
                modBit   = 0;
                modIdx   = 0;
            end
            if (inValid && inReady) begin
                modWord[modBit] = refBit(inCoef, modT, modTHalf);
                modBit++;
                modIdx++;
                if (modBit == OUT_W) begin
                    expQ.push_back({(modIdx == N), modWord});
                    modBit  = 0;
                    modWord = '0;
                end
            end
            if (outValid && outReady) begin
                if (expQ.size() == 0) begin
                    checkOutput("queuedWords", expQ.size(), 1);
                end else begin
                    logic [32:0] e;
                    e = expQ.pop_front();
                    checkOutput("word", outWord, e[31:0]);
                    checkOutput("last", outLast, e[32]);
                end
                capQ.push_back(outWord);
                capLastQ.push_back(outLast);
                popCnt++;
            end
            if (done) doneCnt++;
            prevStall = outValid && !outReady;
            prevWord  = outWord;
            prevLast  = outLast;
        end
    end

    always @(negedge clk) begin
        if (sResetN && sOutValid && sOutReady) begin
            sCapQ.push_back(sOutWord);
            sLastQ.push_back(sOutLast);
        end
    end

    function automatic logic [29:0] coefFor(input int mode, input int i, input logic [29:0] tv, input logic [28:0] th);
        logic [29:0] h = {1'b0, th};
        case (mode)
            0: return tv + ((i % 2 == 1) ? 30'h1000_0000 : 30'h0);
            1: return 30'($urandom);
            2: case (i)
                   0: return tv - h + 30'd1;
                   1: return tv - h;
                   2: return tv - h - 30'd1;
                   3: return tv + h - 30'd1;
                   4: return tv + h;
                   5: return tv + h + 30'd1;
                   default: return tv;
               endcase
            default: case (i)
                   0: return 30'h0;
                   1: return 30'h3FFF_FFFF;
                   2: return h - 30'd1;
                   3: return h;
                   default: return 30'h3FFF_FFFF;
               endcase
        endcase
    endfunction

    task automatic applyStimulus(input logic [29:0] c, input int gap);
        bit acc = 1'b0;
        if (aborted) return;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        inValid = 1'b1;
        inCoef  = c;
        for (int k = 0; k < 500 && !acc; k++) begin
            @(negedge clk);
            acc = inReady;
            @(posedge clk);
            #1;
        end
        inValid = 1'b0;
        if (!acc) begin
            checkOutput("acceptTimeout", acc, 1);
            aborted = 1'b1;
        end
    endtask

    task automatic startPoly(input logic [29:0] tv, input logic [28:0] thv);
        t          = tv;
        tHalf      = thv;
        start      = 1'b1;
        startCycle = cycleCnt;
        @(posedge clk);
        #1;
        start = 1'b0;
        t     = 30'($urandom);
        tHalf = 29'($urandom);
        checkOutput("armBusy", busy, 1);
        checkOutput("armReady", inReady, 1);
    endtask

    task automatic sendPoly(input int mode, input logic [29:0] tv, input logic [28:0] thv, input int maxGap);
        for (int i = 0; i < N; i++) begin
            applyStimulus(coefFor(mode, i, tv, thv), (maxGap > 0) ? $urandom_range(0, maxGap) : 0);
        end
    endtask

    task automatic waitDone();
        bit seen = 1'b0;
        for (int k = 0; k < 3000 && !seen; k++) begin
            @(negedge clk);
            if (done) begin
                seen          = 1'b1;
                doneCycleSeen = cycleCnt;
            end
        end
        @(posedge clk);
        #1;
        if (!seen) checkOutput("doneTimeout", seen, 1);
    endtask

    task automatic checkPoly(input string tag, input int popBase, input int doneBase);
        checkOutput({tag, "Words"}, popCnt - popBase, WORDS);
        checkOutput({tag, "Pending"}, expQ.size(), 0);
        checkOutput({tag, "DoneCount"}, doneCnt - doneBase, 1);
        checkOutput({tag, "BusyAfter"}, busy, 0);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "Busy"}, busy, 0);
        checkOutput({tag, "InReady"}, inReady, 0);
        checkOutput({tag, "OutValid"}, outValid, 0);
        checkOutput({tag, "OutLast"}, outLast, 0);
        checkOutput({tag, "Done"}, done, 0);
        checkOutput({tag, "OutWord"}, outWord, 0);
    endtask

    initial begin
        int popBase;
        int doneBase;
        resetN  = 1'b0; start = 1'b0; inValid = 1'b0; inCoef = '0; t = '0; tHalf = '0;
        sResetN = 1'b0; sStart = 1'b0; sInValid = 1'b0; sInCoef = '0; sT = '0; sTHalf = '0;
        sOutReady = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkResetState("reset");
        resetN  = 1'b1;
        sResetN = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] basic decode");
        popBase = popCnt; doneBase = doneCnt;
        startPoly(30'h2000_0000, 29'h1000_0000);
        sendPoly(0, 30'h2000_0000, 29'h1000_0000, 0);
        waitDone();
        checkOutput("basicLatency", doneCycleSeen - startCycle, N + 2);
        checkOutput("basicWord0", capQ[popBase], 32'h5555_5555);
        checkOutput("basicWord31", capQ[popBase + 31], 32'h5555_5555);
        checkOutput("basicLast30", capLastQ[popBase + 30], 0);
        checkOutput("basicLast31", capLastQ[popBase + 31], 1);
        checkPoly("basic", popBase, doneBase);

        $display("[TB] boundaries");
        popBase = popCnt; doneBase = doneCnt;
        startPoly(30'h2000_0000, 29'h1000_0000);
        sendPoly(2, 30'h2000_0000, 29'h1000_0000, 0);
        waitDone();
        checkOutput("boundWord0", capQ[popBase], 32'hFFFF_FFC9);
        checkPoly("bound", popBase, doneBase);
        popBase = popCnt; doneBase = doneCnt;
        startPoly(30'h0, 29'h1000_0000);
        sendPoly(3, 30'h0, 29'h1000_0000, 0);
        waitDone();
        checkOutput("zeroWord0", capQ[popBase], 32'h0000_0005);
        checkOutput("zeroWord1", capQ[popBase + 1], 32'h0);
        checkPoly("zero", popBase, doneBase);

        $display("[TB] backpressure");
        popBase = popCnt; doneBase = doneCnt;
        fork
            begin
                startPoly(30'h2000_0000, 29'h1000_0000);
                sendPoly(1, 30'h2000_0000, 29'h1000_0000, 0);
            end
            begin
                repeat (300) @(posedge clk);
                #1;
                readyMode = 2;
                repeat (100) @(posedge clk);
                @(negedge clk);
                checkOutput("bpInReady", inReady, 0);
                checkOutput("bpOutValid", outValid, 1);
                @(posedge clk);
                #1;
                readyMode = 1;
            end
        join
        waitDone();
        checkPoly("bp", popBase, doneBase);

        $display("[TB] input gaps and re-arm");
        popBase = popCnt; doneBase = doneCnt;
        fork
            begin
                startPoly(30'h1555_5555, 29'h0AAA_AAAA);
                sendPoly(1, 30'h1555_5555, 29'h0AAA_AAAA, 2);
                waitDone();
            end
            begin
                repeat (400) @(posedge clk);
                #1;
                start = 1'b1; t = 30'h0; tHalf = 29'h0;
                @(posedge clk);
                #1;
                start = 1'b0;
            end
        join
        checkPoly("gapA", popBase, doneBase);
        popBase = popCnt; doneBase = doneCnt;
        startPoly(30'h2AAA_AAAA, 29'h0555_5555);
        sendPoly(1, 30'h2AAA_AAAA, 29'h0555_5555, 1);
        waitDone();
        checkPoly("gapB", popBase, doneBase);
        readyMode = 0;

        $display("[TB] reset mid-operation");
        startPoly(30'h2000_0000, 29'h1000_0000);
        for (int i = 0; i < 500; i++) applyStimulus(coefFor(1, i, 30'h0, 29'h0), 0);
        resetN = 1'b0;
        @(posedge clk);
        #1;
        checkResetState("midReset");
        resetN = 1'b1;
        @(posedge clk);
        #1;
        popBase = popCnt; doneBase = doneCnt;
        startPoly(30'h2000_0000, 29'h1000_0000);
        sendPoly(0, 30'h2000_0000, 29'h1000_0000, 0);
        waitDone();
        checkOutput("rerunWord0", capQ[popBase], 32'h5555_5555);
        checkOutput("rerunWord31", capQ[popBase + 31], 32'h5555_5555);
        checkPoly("rerun", popBase, doneBase);

        $display("[TB] small parameter set");
        sT = 16'h4000; sTHalf = 15'h1000; sStart = 1'b1;
        @(posedge clk);
        #1;
        sStart = 1'b0; sT = 16'h0; sTHalf = 15'h0;
        for (int i = 0; i < 64; i++) begin
            logic [15:0] c;
            bit acc;
            case (i)
                0:       c = 16'h4FFF;
                1:       c = 16'h5000;
                2:       c = 16'h3001;
                3:       c = 16'h3000;
                default: c = 16'h3000 + 16'($urandom_range(0, 16'h2000));
            endcase
            sExp[i / 8][i % 8] = refBit(c, 16'h4000, 15'h1000);
            sInValid = 1'b1; sInCoef = c; acc = 1'b0;
            for (int k = 0; k < 50 && !acc; k++) begin
                @(negedge clk);
                acc = sInReady;
                @(posedge clk);
                #1;
            end
            sInValid = 1'b0;
            if (!acc) checkOutput("smallAccept", acc, 1);
        end
        begin
            bit seen = 1'b0;
            for (int k = 0; k < 50 && !seen; k++) begin
                @(negedge clk);
                seen = sDone;
            end
            checkOutput("smallDone", seen, 1);
        end
        checkOutput("smallWords", sCapQ.size(), 8);
        for (int k = 0; k < 8 && k < sCapQ.size(); k++) begin
            checkOutput($sformatf("smallWord%0d", k), sCapQ[k], sExp[k]);
            checkOutput($sformatf("smallLast%0d", k), sLastQ[k], (k == 7));
        end
        if (sCapQ.size() > 0) checkOutput("smallNibble", sCapQ[0] & 8'h0F, 8'h05);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
